exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: DATA_W, default 8, datapath width; only 8 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation presented this cycle.
REQ-005 in_ready  output  1  unit can accept an operation this cycle.
REQ-006 op  input  3  opcode (see REQ-012).
REQ-007 rd  input  3  destination register index.
REQ-008 a  input  8  operand A, taken from register-file read port 1.
REQ-009 b  input  8  operand B, taken from register-file read port 2.
REQ-010 flush  input  1  abort any in-flight operation; block acceptance this cycle.
REQ-011 Outputs, in order:
- RegWrite  output  1  one-cycle write strobe to the register file.
- WriteReg  output  3  destination index.
- WriteData  output  8  result.
- flags  output  3  {Z,C,N}.
- busy  output  1  multiply in progress.

Function
REQ-012 Opcodes:
- 000 ADD: a+b; C = carry out.
- 001 SUB: a-b; C = borrow.
- 010 AND, 011 OR, 100 XOR: C = 0.
- 101 SHL: a<<1; C = a[7].
- 110 SHR: a>>1 logical; C = a[0].
- 111 MUL: low 8 bits of a*b; C = OR of the high product byte.
REQ-013 Flags: Z = (result == 0); N = result[7]; all three update only on the cycle RegWrite is asserted.
REQ-014 Acceptance: an operation is accepted at a rising edge when in_valid=1, in_ready=1 and flush=0.
REQ-015 in_ready is combinational and equals (state == IDLE).
REQ-016 FSM states IDLE and MUL.
- IDLE -> MUL on an accepted op=111.
- MUL -> IDLE after the 8th iteration edge, or on flush.
REQ-017 Non-MUL ops: accepted at edge k -> RegWrite=1 with WriteReg/WriteData valid for exactly the cycle after edge k. The unit stays in IDLE, so back-to-back acceptance sustains one result per cycle.
REQ-018 MUL: a and b are latched at acceptance; one shift-add iteration per edge. RegWrite=1 for the single cycle after edge k+8.
REQ-019 busy = (state == MUL), and in_ready=0 throughout MUL. in_ready is 1 in the cycle RegWrite presents the MUL result.
REQ-020 RegWrite is 0 in every cycle not named in REQ-017/REQ-018; WriteReg and WriteData hold their last values when RegWrite=0.
REQ-021 flush in MUL: return to IDLE at that edge; no RegWrite is ever produced for the aborted op; flags are unchanged.
REQ-022 flush together with in_valid in IDLE: the op is not accepted. A RegWrite already registered for the current cycle is not suppressed.
REQ-023 rd=0 is an ordinary destination; there is no hardwired zero register.
REQ-024 All arithmetic wraps modulo 256; operand values are unsigned for C and MUL.

Reset
REQ-025 rst=1 at an edge: state=IDLE, RegWrite=0, WriteReg=0, WriteData=0, flags=000, busy=0, multiplier registers cleared.
REQ-026 rst has priority over flush and in_valid, including mid-MUL: no result from the aborted op is ever emitted.
REQ-027 in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-028 Shared package cpu_pkg holds: opcode localparams, the FSM state typedef, flag bit positions, and DATA_W.
REQ-029 One sub-module, mul_seq, implements the 8-iteration shift-add multiplier with start/done handshake and a synchronous clear driven by rst or flush.
REQ-030 All outputs are registered; only in_ready and busy derive directly from the state register.

Verification
REQ-031 ADD a=200, b=100, rd=3 -> next cycle RegWrite=1, WriteReg=3, WriteData=0x2C, flags Z=0 C=1 N=0.
REQ-032 SUB a=5, b=5 -> WriteData=0x00, Z=1 C=0 N=0. Then SUB a=3, b=5 -> WriteData=0xFE, Z=0 C=1 N=1 on the following cycle (back-to-back).
REQ-033 MUL a=15, b=17, rd=6 -> in_ready=0 and busy=1 for 8 cycles; then one RegWrite with WriteReg=6, WriteData=0xFF, C=0, N=1. MUL a=16, b=16 -> WriteData=0x00, Z=1, C=1.
REQ-034 MUL accepted, flush asserted 4 cycles later -> no RegWrite at all, in_ready=1 the next cycle, flags equal their prior value.
REQ-035 rst mid-MUL after 3 iterations -> all outputs per REQ-025 next cycle, no RegWrite afterwards. A subsequent ADD 1+1 -> WriteData=0x02.
REQ-036 in_valid=1 with flush=1 (op ADD) -> no RegWrite. in_valid=1 with MUL busy -> op not accepted, and the bench observes in_ready=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the execution unit and its multiplier.
//   DATA_W          datapath width (only 8 is supported)
//   Op*             3-bit opcode encodings
//   state_t         execution-unit FSM state
//   Flag*           bit positions inside the {Z,C,N} flags vector
//   aluCompute()    single-cycle result and carry for every non-MUL opcode
//   makeFlags()     packs Z/C/N for a finished result
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } state_t;

  // flags = {Z, C, N}
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagN = 0;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
  } aluOut_t;

  function automatic aluOut_t aluCompute(input logic [2:0]        op,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
    aluOut_t         res;
    logic [DATA_W:0] wide;
    res  = '0;
    wide = '0;
    case (op)
      OpAdd: begin
        wide       = {1'b0, a} + {1'b0, b};
        res.result = wide[DATA_W-1:0];
        res.carry  = wide[DATA_W];
      end
      OpSub: begin
        // Top bit of the widened difference is the borrow.
        wide       = {1'b0, a} - {1'b0, b};
        res.result = wide[DATA_W-1:0];
        res.carry  = wide[DATA_W];
      end
      OpAnd: res.result = a & b;
      OpOr:  res.result = a | b;
      OpXor: res.result = a ^ b;
      OpShl: begin
        res.result = {a[DATA_W-2:0], 1'b0};
        res.carry  = a[DATA_W-1];
      end
      OpShr: begin
        res.result = {1'b0, a[DATA_W-1:1]};
        res.carry  = a[0];
      end
      // MUL is produced by the sequential multiplier, not here.
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] makeFlags(input logic [DATA_W-1:0] result,
                                           input logic              carry);
    logic [2:0] f;
    f        = '0;
    f[FlagZ] = (result == '0);
    f[FlagC] = carry;
    f[FlagN] = result[DATA_W-1];
    return f;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// mul_seq: 8-iteration shift-add unsigned multiplier.
//   clk      clock, rising edge
//   clear    synchronous clear (rst or flush); wins over start
//   start    load a/b and begin; one iteration per following edge
//   a, b     operands, sampled on the start edge
//   done     high in the cycle whose closing edge performs the 8th iteration
//   product  combinational value the accumulator takes at that edge; when done
//            is high it is the full 16-bit product
module mul_seq
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  logic [2*DATA_W-1:0] mcandQ;
  logic [DATA_W-1:0]   mplierQ;
  logic [2*DATA_W-1:0] accQ;
  logic [2:0]          countQ;
  logic                activeQ;
  logic [2*DATA_W-1:0] addend;

  always_comb begin
    addend  = mplierQ[0] ? mcandQ : '0;
    product = accQ + addend;
    done    = activeQ && (countQ == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      countQ  <= '0;
      activeQ <= 1'b0;
    end else if (start) begin
      mcandQ  <= {{DATA_W{1'b0}}, a};
      mplierQ <= b;
      accQ    <= '0;
      countQ  <= '0;
      activeQ <= 1'b1;
    end else if (activeQ) begin
      accQ    <= product;
      mcandQ  <= {mcandQ[2*DATA_W-2:0], 1'b0};
      mplierQ <= {1'b0, mplierQ[DATA_W-1:1]};
      countQ  <= countQ + 3'd1;
      if (done) begin
        activeQ <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue execute stage with a register-file write port.
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  operation handshake; in_ready is high only in IDLE
//   op, rd, a, b         opcode, destination index and operands
//   flush                aborts an in-flight MUL and blocks acceptance
//   RegWrite             one-cycle write strobe
//   WriteReg, WriteData  destination and result, held while RegWrite is low
//   flags                {Z,C,N} of the last written result
//   busy                 multiply in progress
// Logic ops complete in one cycle; MUL runs on mul_seq for eight more edges.
module exec_unit #(
  parameter int unsigned DATA_W = 8  // only 8 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [2:0]        rd,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              RegWrite,
  output logic [2:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [2:0]        flags,
  output logic              busy
);

  import cpu_pkg::*;

  state_t                stateQ;
  logic [2:0]            mulRdQ;
  logic                  accept;
  logic                  mulStart;
  logic                  mulClear;
  logic                  mulDone;
  logic [2*DATA_W-1:0]   mulProduct;
  aluOut_t               aluOut;

  assign in_ready = (stateQ == StIdle);
  assign busy     = (stateQ == StMul);

  always_comb begin
    accept   = in_valid && in_ready && !flush;
    mulStart = accept && (op == OpMul);
    mulClear = rst || flush;
    aluOut   = aluCompute(op, a, b);
  end

  mul_seq u_mul (
    .clk     (clk),
    .clear   (mulClear),
    .start   (mulStart),
    .a       (a),
    .b       (b),
    .done    (mulDone),
    .product (mulProduct)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      mulRdQ    <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      flags     <= '0;
    end else begin
      RegWrite <= 1'b0;
      case (stateQ)
        StIdle: begin
          if (accept) begin
            if (op == OpMul) begin
              stateQ <= StMul;
              mulRdQ <= rd;
            end else begin
              RegWrite  <= 1'b1;
              WriteReg  <= rd;
              WriteData <= aluOut.result;
              flags     <= makeFlags(aluOut.result, aluOut.carry);
            end
          end
        end
        StMul: begin
          // Flush beats completion: an aborted MUL never writes back.
          if (flush) begin
            stateQ <= StIdle;
          end else if (mulDone) begin
            stateQ    <= StIdle;
            RegWrite  <= 1'b1;
            WriteReg  <= mulRdQ;
            WriteData <= mulProduct[DATA_W-1:0];
            flags     <= makeFlags(mulProduct[DATA_W-1:0], |mulProduct[2*DATA_W-1:DATA_W]);
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [2:0] rd;
  logic [7:0] a;
  logic [7:0] b;
  logic       flush;
  logic       RegWrite;
  logic [2:0] WriteReg;
  logic [7:0] WriteData;
  logic [2:0] flags;
  logic       busy;

  exec_unit #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [2:0] wreg;
    logic [7:0] data;
    logic [2:0] fl;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] expReg;
  logic [7:0] expData;
  logic [2:0] expFlags;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer arithmetic, flags {Z,C,N}.
  function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] r, output logic [2:0] fl);
    int   v;
    logic c;
    v = 0;
    c = 1'b0;
    case (o)
      3'd0: begin v = int'(x) + int'(y); c = (v > 255); end
      3'd1: begin v = int'(x) - int'(y); c = (v < 0); end
      3'd2: v = int'(x & y);
      3'd3: v = int'(x | y);
      3'd4: v = int'(x ^ y);
      3'd5: begin v = int'(x) * 2; c = x[7]; end
      3'd6: begin v = int'(x) / 2; c = x[0]; end
      default: begin v = int'(x) * int'(y); c = (v > 255); end
    endcase
    r  = v[7:0];
    fl = {(r == 8'd0), c, r[7]};
  endfunction

  task automatic drive(input logic v, input logic [2:0] o, input logic [2:0] r,
                       input logic [7:0] x, input logic [7:0] y, input logic f);
    in_valid = v;
    op       = o;
    rd       = r;
    a        = x;
    b        = y;
    flush    = f;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Drive an op that will be accepted and queue its expected write-back.
  task automatic send(input logic [2:0] o, input logic [2:0] r, input logic [7:0] x,
                      input logic [7:0] y);
    logic [7:0] res;
    logic [2:0] fl;
    drive(1'b1, o, r, x, y, 1'b0);
    model(o, x, y, res, fl);
    sb.push_back('{cyc + ((o == 3'd7) ? 9 : 1), r, res, fl});
  endtask

  task automatic observe();
    logic strobe;
    strobe = (sb.size() > 0) && (sb[0].due == cyc);
    check("RegWrite", 16'(RegWrite), 16'(strobe));
    if (strobe) begin
      expReg   = sb[0].wreg;
      expData  = sb[0].data;
      expFlags = sb[0].fl;
      void'(sb.pop_front());
    end
    check("WriteReg", 16'(WriteReg), 16'(expReg));
    check("WriteData", 16'(WriteData), 16'(expData));
    check("flags", 16'(flags), 16'(expFlags));
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    expReg   = '0;
    expData  = '0;
    expFlags = '0;
    check("rst_RegWrite", 16'(RegWrite), 16'h0);
    check("rst_WriteReg", 16'(WriteReg), 16'h0);
    check("rst_WriteData", 16'(WriteData), 16'h0);
    check("rst_flags", 16'(flags), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_in_ready", 16'(in_ready), 16'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    doReset();

    // ADD with carry, then two back-to-back SUBs.
    send(OpAdd, 3'd3, 8'd200, 8'd100);
    tick();
    check("add_data", 16'(WriteData), 16'h2C);
    check("add_reg", 16'(WriteReg), 16'h3);
    check("add_flags", 16'(flags), 16'b010);
    send(OpSub, 3'd1, 8'd5, 8'd5);
    tick();
    check("sub0_data", 16'(WriteData), 16'h00);
    check("sub0_flags", 16'(flags), 16'b100);
    send(OpSub, 3'd2, 8'd3, 8'd5);
    tick();
    check("sub1_data", 16'(WriteData), 16'hFE);
    check("sub1_flags", 16'(flags), 16'b011);
    idle();
    tick();

    // Back-to-back single-cycle ops with random operands.
    for (int i = 0; i < 16; i++) begin
      send(3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      tick();
    end
    idle();
    tick();

    // MUL 15*17: eight busy cycles, then the write-back.
    check("mul_pre_ready", 16'(in_ready), 16'h1);
    send(OpMul, 3'd6, 8'd15, 8'd17);
    tick();
    idle();
    check("mul_ready0", 16'(in_ready), 16'h0);
    check("mul_busy0", 16'(busy), 16'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("mul_ready", 16'(in_ready), 16'h0);
      check("mul_busy", 16'(busy), 16'h1);
    end
    tick();
    check("mul_done_ready", 16'(in_ready), 16'h1);
    check("mul_done_busy", 16'(busy), 16'h0);
    check("mul_data", 16'(WriteData), 16'hFF);
    check("mul_reg", 16'(WriteReg), 16'h6);
    check("mul_flags", 16'(flags), 16'b001);

    // MUL 16*16: zero low byte, carry from high byte.
    send(OpMul, 3'd4, 8'd16, 8'd16);
    tick();
    idle();
    repeat (7) tick();
    tick();
    check("mul2_data", 16'(WriteData), 16'h00);
    check("mul2_flags", 16'(flags), 16'b110);

    // MUL flushed four cycles after acceptance: no write-back, flags kept.
    drive(1'b1, OpMul, 3'd5, 8'd9, 8'd9, 1'b0);
    tick();
    idle();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 16'(in_ready), 16'h1);
    check("flush_busy", 16'(busy), 16'h0);
    check("flush_flags", 16'(flags), 16'b110);
    repeat (10) tick();

    // Valid together with flush in IDLE is not accepted.
    drive(1'b1, OpAdd, 3'd1, 8'd10, 8'd20, 1'b1);
    tick();
    idle();
    tick();
    tick();
    check("vf_ready", 16'(in_ready), 16'h1);

    // Valid while a MUL is busy is not accepted.
    send(OpMul, 3'd7, 8'd3, 8'd4);
    tick();
    drive(1'b1, OpAdd, 3'd2, 8'd1, 8'd1, 1'b0);
    check("busy_ready0", 16'(in_ready), 16'h0);
    tick();
    check("busy_ready1", 16'(in_ready), 16'h0);
    idle();
    repeat (6) tick();
    tick();
    check("mul3_data", 16'(WriteData), 16'h0C);
    check("mul3_reg", 16'(WriteReg), 16'h7);
    repeat (3) tick();

    // Reset after three MUL iterations: nothing from the aborted op.
    drive(1'b1, OpMul, 3'd3, 8'd100, 8'd3, 1'b0);
    tick();
    idle();
    tick();
    tick();
    doReset();
    repeat (12) tick();
    send(OpAdd, 3'd0, 8'd1, 8'd1);
    tick();
    check("post_rst_data", 16'(WriteData), 16'h02);
    check("post_rst_reg0", 16'(WriteReg), 16'h0);
    idle();
    repeat (2) tick();

    check("sb_empty", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
